// File: rtl/ring_node_mc.sv
// Ring interconnect node with NUM_PE buffered injection channels and a
// pass-through ring port; ring traffic always owns its slot.
package ring_node_mc_pkg;
  localparam int unsigned CELL_ID_W = 8;
  localparam int unsigned FORCE_W   = 16;

  typedef struct packed {
    logic [FORCE_W-1:0] fx;
    logic [FORCE_W-1:0] fy;
    logic [FORCE_W-1:0] fz;
  } force_data_t;

  typedef struct packed {
    logic [CELL_ID_W-1:0] dest_id;
    force_data_t          payload;
  } packet_t;
endpackage

module ring_node_mc
  import ring_node_mc_pkg::*;
#(
  parameter int unsigned HOME_CELL_ID = 0,
  parameter int unsigned NUM_PE       = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  packet_t [NUM_PE-1:0]  pe_pkt_in,
  input  logic    [NUM_PE-1:0]  pe_pkt_valid,
  output logic    [NUM_PE-1:0]  pe_ready,
  input  packet_t               prev_pkt_in,
  input  logic                  prev_pkt_valid,
  output force_data_t           fc_data_out,
  output logic                  fc_data_valid,
  output packet_t               nxt_pkt_out,
  output logic                  nxt_pkt_valid
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [CELL_ID_W-1:0] HOME_ID  = CELL_ID_W'(HOME_CELL_ID);
  localparam logic [CW-1:0]        CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0]        PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0]        PE_LAST  = PW'(NUM_PE - 1);

  packet_t       mem_q    [NUM_PE][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q [NUM_PE];
  logic [AW-1:0] wr_ptr_d [NUM_PE];
  logic [AW-1:0] rd_ptr_q [NUM_PE];
  logic [AW-1:0] rd_ptr_d [NUM_PE];
  logic [CW-1:0] cnt_q    [NUM_PE];
  logic [CW-1:0] cnt_d    [NUM_PE];
  packet_t       head_c   [NUM_PE];

  logic [PW-1:0] fc_ptr_q, fc_ptr_d, nxt_ptr_q, nxt_ptr_d;
  logic [PW-1:0] fc_idx_c, nxt_idx_c;
  logic          fc_found_c, nxt_found_c;
  logic          ring_fc_c, ring_nxt_c;
  logic [NUM_PE-1:0] push_c, pop_c, fc_elig_c, nxt_elig_c;

  force_data_t fc_data_q, fc_data_d;
  logic        fc_valid_q, fc_valid_d;
  packet_t     nxt_pkt_q, nxt_pkt_d;
  logic        nxt_valid_q, nxt_valid_d;

  // Index k positions after base, modulo NUM_PE.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_PE) s = s - NUM_PE;
    return PW'(s);
  endfunction

  function automatic logic [PW-1:0] pe_inc(input logic [PW-1:0] g);
    return (g == PE_LAST) ? '0 : g + PW'(1);
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  assign ring_fc_c  = prev_pkt_valid && (prev_pkt_in.dest_id == HOME_ID);
  assign ring_nxt_c = prev_pkt_valid && (prev_pkt_in.dest_id != HOME_ID);

  // FIFO heads and per-slot eligibility
  always_comb begin
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      head_c[i]     = mem_q[i][rd_ptr_q[i]];
      pe_ready[i]   = (cnt_q[i] != CNT_FULL);
      fc_elig_c[i]  = (cnt_q[i] != '0) && (head_c[i].dest_id == HOME_ID);
      nxt_elig_c[i] = (cnt_q[i] != '0) && (head_c[i].dest_id != HOME_ID);
    end
  end

  // Round-robin search over free slots only
  always_comb begin
    fc_found_c  = 1'b0;
    fc_idx_c    = fc_ptr_q;
    nxt_found_c = 1'b0;
    nxt_idx_c   = nxt_ptr_q;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      if (!fc_found_c && !ring_fc_c && fc_elig_c[rr_idx(fc_ptr_q, k)]) begin
        fc_found_c = 1'b1;
        fc_idx_c   = rr_idx(fc_ptr_q, k);
      end
      if (!nxt_found_c && !ring_nxt_c && nxt_elig_c[rr_idx(nxt_ptr_q, k)]) begin
        nxt_found_c = 1'b1;
        nxt_idx_c   = rr_idx(nxt_ptr_q, k);
      end
    end
  end

  // FIFO pointer/count next state; a full FIFO refuses pushes even when popped
  always_comb begin
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      push_c[i]   = pe_pkt_valid[i] && (cnt_q[i] != CNT_FULL);
      pop_c[i]    = (fc_found_c && (fc_idx_c == PW'(i))) ||
                    (nxt_found_c && (nxt_idx_c == PW'(i)));
      wr_ptr_d[i] = push_c[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
      rd_ptr_d[i] = pop_c[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
      case ({push_c[i], pop_c[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Slot winners and arbiter pointer advance
  always_comb begin
    fc_valid_d  = 1'b0;
    fc_data_d   = '0;
    nxt_valid_d = 1'b0;
    nxt_pkt_d   = '0;
    fc_ptr_d    = fc_ptr_q;
    nxt_ptr_d   = nxt_ptr_q;
    if (ring_fc_c) begin
      fc_valid_d = 1'b1;
      fc_data_d  = prev_pkt_in.payload;
    end else if (fc_found_c) begin
      fc_valid_d = 1'b1;
      fc_data_d  = head_c[fc_idx_c].payload;
      fc_ptr_d   = pe_inc(fc_idx_c);
    end
    if (ring_nxt_c) begin
      nxt_valid_d = 1'b1;
      nxt_pkt_d   = prev_pkt_in;
    end else if (nxt_found_c) begin
      nxt_valid_d = 1'b1;
      nxt_pkt_d   = head_c[nxt_idx_c];
      nxt_ptr_d   = pe_inc(nxt_idx_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      fc_ptr_q    <= '0;
      nxt_ptr_q   <= '0;
      fc_data_q   <= '0;
      fc_valid_q  <= 1'b0;
      nxt_pkt_q   <= '0;
      nxt_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      fc_ptr_q    <= fc_ptr_d;
      nxt_ptr_q   <= nxt_ptr_d;
      fc_data_q   <= fc_data_d;
      fc_valid_q  <= fc_valid_d;
      nxt_pkt_q   <= nxt_pkt_d;
      nxt_valid_q <= nxt_valid_d;
    end
  end

  // Packet storage needs no reset; occupancy is tracked by the counts
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (push_c[i] && !rst) mem_q[i][wr_ptr_q[i]] <= pe_pkt_in[i];
    end
  end

  assign fc_data_out   = fc_data_q;
  assign fc_data_valid = fc_valid_q;
  assign nxt_pkt_out   = nxt_pkt_q;
  assign nxt_pkt_valid = nxt_valid_q;

endmodule

// File: tb/tb_ring_node_mc.sv
// Bench for ring_node_mc: directed scenarios plus randomized traffic checked
// against a queue-based model of slot allocation and round-robin arbitration.
module tb_ring_node_mc;
  import ring_node_mc_pkg::*;

  localparam int unsigned HOME  = 5;
  localparam int unsigned NPE   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PAY_W = $bits(force_data_t);

  logic                 clk = 1'b0;
  logic                 rst;
  packet_t [NPE-1:0]    pe_pkt_in;
  logic    [NPE-1:0]    pe_pkt_valid;
  logic    [NPE-1:0]    pe_ready;
  packet_t              prev_pkt_in;
  logic                 prev_pkt_valid;
  force_data_t          fc_data_out;
  logic                 fc_data_valid;
  packet_t              nxt_pkt_out;
  logic                 nxt_pkt_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state
  packet_t     mq [NPE][$];
  int          m_fc_ptr, m_nxt_ptr;
  logic        exp_fc_v, exp_nxt_v;
  force_data_t exp_fc_d;
  packet_t     exp_nxt_p;
  logic [NPE-1:0] exp_ready;

  ring_node_mc #(.HOME_CELL_ID(HOME), .NUM_PE(NPE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pe_pkt_in(pe_pkt_in), .pe_pkt_valid(pe_pkt_valid), .pe_ready(pe_ready),
    .prev_pkt_in(prev_pkt_in), .prev_pkt_valid(prev_pkt_valid),
    .fc_data_out(fc_data_out), .fc_data_valid(fc_data_valid),
    .nxt_pkt_out(nxt_pkt_out), .nxt_pkt_valid(nxt_pkt_valid)
  );

  always #5 clk = ~clk;

  function automatic force_data_t pl(input int unsigned x);
    return force_data_t'(PAY_W'(x));
  endfunction

  function automatic packet_t mk_pkt(input int unsigned dest, input force_data_t pay);
    packet_t p;
    p.dest_id = CELL_ID_W'(dest);
    p.payload = pay;
    return p;
  endfunction

  function automatic force_data_t rnd_pay();
    return force_data_t'(PAY_W'({$urandom(), $urandom()}));
  endfunction

  function automatic int unsigned rnd_dest();
    int unsigned r;
    r = $urandom_range(0, 2);
    return (r == 0) ? 5 : ((r == 1) ? 7 : 9);
  endfunction

  task automatic drive_idle();
    prev_pkt_valid = 1'b0;
    prev_pkt_in    = '0;
    pe_pkt_valid   = '0;
    pe_pkt_in      = '0;
  endtask

  // Advance the model by one cycle from the current inputs, then clock the DUT
  task automatic tick();
    bit          fc_busy, nxt_busy;
    int          fc_g, nxt_g, c;
    bit [NPE-1:0] acc;
    packet_t     h;
    if (rst) begin
      for (int i = 0; i < NPE; i++) mq[i].delete();
      m_fc_ptr = 0; m_nxt_ptr = 0;
      exp_fc_v = 1'b0; exp_fc_d = '0; exp_nxt_v = 1'b0; exp_nxt_p = '0;
      exp_ready = '1;
    end else begin
      fc_busy  = prev_pkt_valid && (prev_pkt_in.dest_id == CELL_ID_W'(HOME));
      nxt_busy = prev_pkt_valid && !fc_busy;
      fc_g = -1; nxt_g = -1;
      for (int k = 0; k < NPE; k++) begin
        c = (m_fc_ptr + k) % NPE;
        if (!fc_busy && fc_g < 0 && mq[c].size() > 0) begin
          h = mq[c][0];
          if (h.dest_id == CELL_ID_W'(HOME)) fc_g = c;
        end
        c = (m_nxt_ptr + k) % NPE;
        if (!nxt_busy && nxt_g < 0 && mq[c].size() > 0) begin
          h = mq[c][0];
          if (h.dest_id != CELL_ID_W'(HOME)) nxt_g = c;
        end
      end
      exp_fc_v = fc_busy || (fc_g >= 0);
      exp_fc_d = '0;
      if (fc_busy) exp_fc_d = prev_pkt_in.payload;
      else if (fc_g >= 0) begin h = mq[fc_g][0]; exp_fc_d = h.payload; end
      exp_nxt_v = nxt_busy || (nxt_g >= 0);
      exp_nxt_p = '0;
      if (nxt_busy) exp_nxt_p = prev_pkt_in;
      else if (nxt_g >= 0) exp_nxt_p = mq[nxt_g][0];
      for (int i = 0; i < NPE; i++) acc[i] = pe_pkt_valid[i] && (mq[i].size() != DEPTH);
      if (fc_g >= 0) begin void'(mq[fc_g].pop_front()); m_fc_ptr = (fc_g + 1) % NPE; end
      if (nxt_g >= 0) begin void'(mq[nxt_g].pop_front()); m_nxt_ptr = (nxt_g + 1) % NPE; end
      for (int i = 0; i < NPE; i++) begin
        if (acc[i]) mq[i].push_back(pe_pkt_in[i]);
        exp_ready[i] = (mq[i].size() != DEPTH);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    pe_pkt_valid = 2'b11;
    pe_pkt_in[0] = mk_pkt(7, pl('h0a));
    pe_pkt_in[1] = mk_pkt(5, pl('h0b));
    tick(); tick();
    checks++; if (fc_data_valid !== 1'b0) begin errors++; $display("FAIL reset_fc_valid got %0b exp 0", fc_data_valid); end
    checks++; if (nxt_pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_nxt_valid got %0b exp 0", nxt_pkt_valid); end
    checks++; if (fc_data_out !== '0) begin errors++; $display("FAIL reset_fc_data got %h exp 0", fc_data_out); end
    checks++; if (nxt_pkt_out !== '0) begin errors++; $display("FAIL reset_nxt_pkt got %h exp 0", nxt_pkt_out); end
    checks++; if (pe_ready !== 2'b11) begin errors++; $display("FAIL reset_ready got %b exp 11", pe_ready); end
    rst = 1'b0;
    drive_idle();
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (fc_data_valid !== 1'b0 || nxt_pkt_valid !== 1'b0) begin
        errors++; $display("FAIL reset_push_discarded fc_v %0b nxt_v %0b exp 0 0", fc_data_valid, nxt_pkt_valid);
      end
    end
  endtask

  task automatic test_ring_priority();
    drive_idle();
    pe_pkt_valid[0] = 1'b1;
    pe_pkt_in[0]    = mk_pkt(5, pl('h11));
    tick();
    pe_pkt_valid   = '0;
    prev_pkt_valid = 1'b1;
    prev_pkt_in    = mk_pkt(5, pl('h22));
    tick();
    checks++; if (fc_data_valid !== 1'b1 || fc_data_out !== pl('h22)) begin
      errors++; $display("FAIL prio_ring_first v %0b data %h exp 1 %h", fc_data_valid, fc_data_out, pl('h22));
    end
    checks++; if (nxt_pkt_valid !== 1'b0) begin errors++; $display("FAIL prio_nxt_idle1 got %0b exp 0", nxt_pkt_valid); end
    prev_pkt_valid = 1'b0;
    tick();
    checks++; if (fc_data_valid !== 1'b1 || fc_data_out !== pl('h11)) begin
      errors++; $display("FAIL prio_ch0_second v %0b data %h exp 1 %h", fc_data_valid, fc_data_out, pl('h11));
    end
    checks++; if (nxt_pkt_valid !== 1'b0) begin errors++; $display("FAIL prio_nxt_idle2 got %0b exp 0", nxt_pkt_valid); end
    tick();
    checks++; if (fc_data_valid !== 1'b0) begin errors++; $display("FAIL prio_fc_drained got %0b exp 0", fc_data_valid); end
  endtask

  task automatic test_dual_grant();
    drive_idle();
    pe_pkt_valid = 2'b11;
    pe_pkt_in[0] = mk_pkt(5, pl('h33));
    pe_pkt_in[1] = mk_pkt(7, pl('h44));
    tick();
    pe_pkt_valid = '0;
    tick();
    checks++; if (fc_data_valid !== 1'b1 || nxt_pkt_valid !== 1'b1) begin
      errors++; $display("FAIL dual_both_valid fc_v %0b nxt_v %0b exp 1 1", fc_data_valid, nxt_pkt_valid);
    end
    checks++; if (fc_data_out !== pl('h33)) begin errors++; $display("FAIL dual_fc_data got %h exp %h", fc_data_out, pl('h33)); end
    checks++; if (nxt_pkt_out !== mk_pkt(7, pl('h44))) begin
      errors++; $display("FAIL dual_nxt_pkt got %h exp %h", nxt_pkt_out, mk_pkt(7, pl('h44)));
    end
    tick();
    checks++; if (fc_data_valid !== 1'b0 || nxt_pkt_valid !== 1'b0) begin
      errors++; $display("FAIL dual_idle fc_v %0b nxt_v %0b exp 0 0", fc_data_valid, nxt_pkt_valid);
    end
  endtask

  task automatic test_round_robin();
    packet_t e;
    drive_idle();
    prev_pkt_valid = 1'b1;
    prev_pkt_in    = mk_pkt(9, pl('h99));
    pe_pkt_valid   = 2'b11;
    for (int k = 0; k < 3; k++) begin
      pe_pkt_in[0] = mk_pkt(7, pl('h100 + k));
      pe_pkt_in[1] = mk_pkt(7, pl('h200 + k));
      tick();
      checks++; if (nxt_pkt_valid !== 1'b1 || nxt_pkt_out !== mk_pkt(9, pl('h99))) begin
        errors++; $display("FAIL rr_ring_holds_nxt k=%0d got %h exp %h", k, nxt_pkt_out, mk_pkt(9, pl('h99)));
      end
    end
    drive_idle();
    for (int k = 0; k < 6; k++) begin
      tick();
      e = mk_pkt(7, pl(((k % 2) == 0 ? 'h100 : 'h200) + k / 2));
      checks++; if (nxt_pkt_valid !== 1'b1 || nxt_pkt_out !== e) begin
        errors++; $display("FAIL rr_order k=%0d v %0b got %h exp %h", k, nxt_pkt_valid, nxt_pkt_out, e);
      end
    end
    checks++; if (fc_data_valid !== 1'b0) begin errors++; $display("FAIL rr_fc_idle got %0b exp 0", fc_data_valid); end
  endtask

  task automatic test_full_fifo();
    drive_idle();
    prev_pkt_valid  = 1'b1;
    prev_pkt_in     = mk_pkt(9, pl('h98));
    pe_pkt_valid[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pe_pkt_in[0] = mk_pkt(7, pl('h300 + k));
      tick();
      checks++; if (pe_ready[0] !== (k < 3)) begin
        errors++; $display("FAIL full_ready_fill k=%0d got %0b exp %0b", k, pe_ready[0], (k < 3));
      end
    end
    pe_pkt_in[0] = mk_pkt(7, pl('h3ff));
    tick();
    checks++; if (pe_ready[0] !== 1'b0) begin errors++; $display("FAIL full_fifth_rejected ready %0b exp 0", pe_ready[0]); end
    // ring stops; a push offered while full and being popped is still refused
    prev_pkt_valid = 1'b0;
    pe_pkt_in[0]   = mk_pkt(7, pl('h3fe));
    for (int k = 0; k < 4; k++) begin
      tick();
      pe_pkt_valid = '0;
      checks++; if (nxt_pkt_valid !== 1'b1 || nxt_pkt_out !== mk_pkt(7, pl('h300 + k))) begin
        errors++; $display("FAIL full_drain k=%0d v %0b got %h exp %h", k, nxt_pkt_valid, nxt_pkt_out, mk_pkt(7, pl('h300 + k)));
      end
      checks++; if (pe_ready[0] !== 1'b1) begin errors++; $display("FAIL full_ready_rise k=%0d got %0b exp 1", k, pe_ready[0]); end
    end
    tick();
    checks++; if (nxt_pkt_valid !== 1'b0) begin errors++; $display("FAIL full_no_extra got %0b pkt %h exp 0", nxt_pkt_valid, nxt_pkt_out); end
  endtask

  task automatic test_push_pop_cnt2();
    drive_idle();
    prev_pkt_valid  = 1'b1;
    prev_pkt_in     = mk_pkt(9, pl('h97));
    pe_pkt_valid[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pe_pkt_in[0] = mk_pkt(7, pl('h400 + k));
      tick();
    end
    prev_pkt_valid = 1'b0;
    pe_pkt_in[0]   = mk_pkt(7, pl('h402));
    tick();
    checks++; if (nxt_pkt_valid !== 1'b1 || nxt_pkt_out !== mk_pkt(7, pl('h400))) begin
      errors++; $display("FAIL pp_pop_out v %0b got %h exp %h", nxt_pkt_valid, nxt_pkt_out, mk_pkt(7, pl('h400)));
    end
    prev_pkt_valid = 1'b1;
    prev_pkt_in    = mk_pkt(9, pl('h97));
    pe_pkt_in[0]   = mk_pkt(7, pl('h403));
    tick();
    checks++; if (pe_ready[0] !== 1'b1) begin errors++; $display("FAIL pp_count3_ready got %0b exp 1", pe_ready[0]); end
    pe_pkt_in[0] = mk_pkt(7, pl('h404));
    tick();
    checks++; if (pe_ready[0] !== 1'b0) begin errors++; $display("FAIL pp_count4_ready got %0b exp 0", pe_ready[0]); end
    drive_idle();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (nxt_pkt_valid !== 1'b1 || nxt_pkt_out !== mk_pkt(7, pl('h400 + k))) begin
        errors++; $display("FAIL pp_order k=%0d v %0b got %h exp %h", k, nxt_pkt_valid, nxt_pkt_out, mk_pkt(7, pl('h400 + k)));
      end
    end
    tick();
    checks++; if (nxt_pkt_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got %0b exp 0", nxt_pkt_valid); end
  endtask

  task automatic test_reset_mid();
    drive_idle();
    prev_pkt_valid  = 1'b1;
    prev_pkt_in     = mk_pkt(9, pl('h96));
    pe_pkt_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pe_pkt_in[0] = mk_pkt(7, pl('h500 + k));
      tick();
    end
    checks++; if (nxt_pkt_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %0b exp 1", nxt_pkt_valid); end
    rst          = 1'b1;
    pe_pkt_in[0] = mk_pkt(7, pl('h5ff));
    tick();
    checks++; if (fc_data_valid !== 1'b0 || nxt_pkt_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_valids fc_v %0b nxt_v %0b exp 0 0", fc_data_valid, nxt_pkt_valid);
    end
    checks++; if (nxt_pkt_out !== '0) begin errors++; $display("FAIL rmid_nxt_zero got %h exp 0", nxt_pkt_out); end
    checks++; if (pe_ready !== 2'b11) begin errors++; $display("FAIL rmid_ready got %b exp 11", pe_ready); end
    rst = 1'b0;
    drive_idle();
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (fc_data_valid !== 1'b0 || nxt_pkt_valid !== 1'b0) begin
        errors++; $display("FAIL rmid_flushed n=%0d fc_v %0b nxt_v %0b exp 0 0", n, fc_data_valid, nxt_pkt_valid);
      end
    end
  endtask

  task automatic test_random();
    rst = 1'b1;
    drive_idle();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      prev_pkt_valid = ($urandom_range(0, 9) < 4);
      prev_pkt_in    = mk_pkt(rnd_dest(), rnd_pay());
      for (int c = 0; c < NPE; c++) begin
        pe_pkt_valid[c] = ($urandom_range(0, 9) < 6);
        pe_pkt_in[c]    = mk_pkt(rnd_dest(), rnd_pay());
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
      checks++; if (fc_data_valid !== exp_fc_v) begin
        errors++; $display("FAIL rand_fc_valid n=%0d got %0b exp %0b", n, fc_data_valid, exp_fc_v);
      end
      checks++; if (fc_data_out !== exp_fc_d) begin
        errors++; $display("FAIL rand_fc_data n=%0d got %h exp %h", n, fc_data_out, exp_fc_d);
      end
      checks++; if (nxt_pkt_valid !== exp_nxt_v) begin
        errors++; $display("FAIL rand_nxt_valid n=%0d got %0b exp %0b", n, nxt_pkt_valid, exp_nxt_v);
      end
      checks++; if (nxt_pkt_out !== exp_nxt_p) begin
        errors++; $display("FAIL rand_nxt_pkt n=%0d got %h exp %h", n, nxt_pkt_out, exp_nxt_p);
      end
      checks++; if (pe_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready n=%0d got %b exp %b", n, pe_ready, exp_ready);
      end
    end
    rst = 1'b0;
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_ring_priority();
    test_dual_grant();
    test_round_robin();
    test_full_fifo();
    test_push_pop_cnt2();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
